// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, default opcodes and the 1149.1 next-state function.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_TLR     = 4'd0,
    TAP_RTI     = 4'd1,
    TAP_SEL_DR  = 4'd2,
    TAP_CAP_DR  = 4'd3,
    TAP_SH_DR   = 4'd4,
    TAP_EX1_DR  = 4'd5,
    TAP_PA_DR   = 4'd6,
    TAP_EX2_DR  = 4'd7,
    TAP_UPD_DR  = 4'd8,
    TAP_SEL_IR  = 4'd9,
    TAP_CAP_IR  = 4'd10,
    TAP_SH_IR   = 4'd11,
    TAP_EX1_IR  = 4'd12,
    TAP_PA_IR   = 4'd13,
    TAP_EX2_IR  = 4'd14,
    TAP_UPD_IR  = 4'd15
  } tap_state_t;

  localparam int          DEF_IR_WIDTH      = 4;
  localparam logic [31:0] DEF_IDCODE_VALUE  = 32'h1000_0001;
  localparam logic [3:0]  DEF_IR_IDCODE     = 4'h1;
  localparam logic [3:0]  DEF_IR_GPIO_DATA  = 4'h2;
  localparam logic [3:0]  DEF_IR_GPIO_CONFIG = 4'h3;
  localparam logic [3:0]  DEF_IR_BYPASS     = 4'hF;

  function automatic tap_state_t tap_next(input tap_state_t state, input logic tms);
    tap_state_t nxt;
    nxt = TAP_TLR;
    case (state)
      TAP_TLR:    nxt = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    nxt = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: nxt = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: nxt = tms ? TAP_UPD_DR : TAP_PA_DR;
      TAP_PA_DR:  nxt = tms ? TAP_EX2_DR : TAP_PA_DR;
      TAP_EX2_DR: nxt = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: nxt = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: nxt = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: nxt = tms ? TAP_UPD_IR : TAP_PA_IR;
      TAP_PA_IR:  nxt = tms ? TAP_EX2_IR : TAP_PA_IR;
      TAP_EX2_IR: nxt = tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: nxt = tms ? TAP_SEL_DR : TAP_RTI;
      default:    nxt = TAP_TLR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP state register with next-state logic and the state decodes used by the IR/DR datapath.
//
// state      | meaning
// TAP_TLR    | test logic reset, IR forced to IDCODE
// TAP_RTI    | run-test/idle
// SEL/CAP/SH | select, capture, shift of the DR or IR column
// EX1/PA/EX2 | exit-1, pause, exit-2 of the DR or IR column
// UPD_DR/IR  | update; UPD_IR commits the instruction
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic i_tck,
  input  logic i_rst,
  input  logic i_tms,
  output logic o_next_tlr,
  output logic o_tlr,
  output logic o_capture_dr,
  output logic o_shift_dr,
  output logic o_update_dr,
  output logic o_capture_ir,
  output logic o_shift_ir,
  output logic o_update_ir
);

  tap_state_t r_state;
  tap_state_t w_state_next;

  always_ff @(posedge i_tck or posedge i_rst) begin
    if (i_rst) r_state <= TAP_TLR;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = tap_next(r_state, i_tms);
    o_next_tlr   = 1'b0;
    o_tlr        = 1'b0;
    o_capture_dr = 1'b0;
    o_shift_dr   = 1'b0;
    o_update_dr  = 1'b0;
    o_capture_ir = 1'b0;
    o_shift_ir   = 1'b0;
    o_update_ir  = 1'b0;
    if (w_state_next == TAP_TLR) o_next_tlr = 1'b1;
    case (r_state)
      TAP_TLR:    o_tlr        = 1'b1;
      TAP_CAP_DR: o_capture_dr = 1'b1;
      TAP_SH_DR:  o_shift_dr   = 1'b1;
      TAP_UPD_DR: o_update_dr  = 1'b1;
      TAP_CAP_IR: o_capture_ir = 1'b1;
      TAP_SH_IR:  o_shift_ir   = 1'b1;
      TAP_UPD_IR: o_update_ir  = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: rtl/jtag_tap.sv
// 1149.1 TAP: instruction register, IDCODE/BYPASS data registers and the TDO mux
// feeding the GPIO scan-chain block.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int                    IR_WIDTH       = DEF_IR_WIDTH,
  parameter logic [31:0]           IDCODE_VALUE   = DEF_IDCODE_VALUE,
  parameter logic [IR_WIDTH-1:0]   IR_IDCODE      = IR_WIDTH'(DEF_IR_IDCODE),
  parameter logic [IR_WIDTH-1:0]   IR_GPIO_DATA   = IR_WIDTH'(DEF_IR_GPIO_DATA),
  parameter logic [IR_WIDTH-1:0]   IR_GPIO_CONFIG = IR_WIDTH'(DEF_IR_GPIO_CONFIG),
  parameter logic [IR_WIDTH-1:0]   IR_BYPASS      = IR_WIDTH'(DEF_IR_BYPASS)
) (
  input  logic tck,
  input  logic reset,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_ena,
  input  logic gpios_tdo,
  output logic capture_dr,
  output logic shift_dr,
  output logic update_dr,
  output logic gpio_data_ir,
  output logic gpio_config_ir,
  output logic test_logic_reset
);

  logic                r_tdo;
  logic                r_tdo_ena;
  logic [IR_WIDTH-1:0] r_ir;
  logic [IR_WIDTH-1:0] r_ir_sr;
  logic [31:0]         r_idcode_sr;
  logic                r_bypass;

  logic w_next_tlr, w_tlr;
  logic w_capture_dr, w_shift_dr, w_update_dr;
  logic w_capture_ir, w_shift_ir, w_update_ir;
  logic w_sel_idcode, w_sel_gdata, w_sel_gcfg, w_sel_bypass;
  logic w_dr_tdo;

  jtag_tap_fsm u_fsm (
    .i_tck        (tck),
    .i_rst        (reset),
    .i_tms        (tms),
    .o_next_tlr   (w_next_tlr),
    .o_tlr        (w_tlr),
    .o_capture_dr (w_capture_dr),
    .o_shift_dr   (w_shift_dr),
    .o_update_dr  (w_update_dr),
    .o_capture_ir (w_capture_ir),
    .o_shift_ir   (w_shift_ir),
    .o_update_ir  (w_update_ir)
  );

  // Opcodes are distinct, so at most one named select is high; anything else is BYPASS.
  assign w_sel_idcode = (r_ir == IR_IDCODE);
  assign w_sel_gdata  = (r_ir == IR_GPIO_DATA);
  assign w_sel_gcfg   = (r_ir == IR_GPIO_CONFIG);
  assign w_sel_bypass = (r_ir == IR_BYPASS) || !(w_sel_idcode || w_sel_gdata || w_sel_gcfg);

  // Entering TLR clears partial shifts and restores IDCODE for the whole TLR cycle.
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      r_ir    <= IR_IDCODE;
      r_ir_sr <= '0;
    end else if (w_next_tlr) begin
      r_ir    <= IR_IDCODE;
      r_ir_sr <= '0;
    end else begin
      if (w_capture_ir)    r_ir_sr <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
      else if (w_shift_ir) r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
      if (w_update_ir)     r_ir    <= r_ir_sr;
    end
  end

  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      r_idcode_sr <= '0;
      r_bypass    <= 1'b0;
    end else if (w_next_tlr) begin
      r_idcode_sr <= '0;
      r_bypass    <= 1'b0;
    end else begin
      if (w_sel_idcode && w_capture_dr)    r_idcode_sr <= IDCODE_VALUE;
      else if (w_sel_idcode && w_shift_dr) r_idcode_sr <= {tdi, r_idcode_sr[31:1]};
      if (w_sel_bypass && w_capture_dr)    r_bypass    <= 1'b0;
      else if (w_sel_bypass && w_shift_dr) r_bypass    <= tdi;
    end
  end

  always_comb begin
    w_dr_tdo = r_bypass;
    if (w_sel_idcode)                   w_dr_tdo = r_idcode_sr[0];
    else if (w_sel_gdata || w_sel_gcfg) w_dr_tdo = gpios_tdo;
  end

  always_ff @(negedge tck or posedge reset) begin
    if (reset) begin
      r_tdo     <= 1'b0;
      r_tdo_ena <= 1'b0;
    end else if (w_shift_ir) begin
      r_tdo     <= r_ir_sr[0];
      r_tdo_ena <= 1'b1;
    end else if (w_shift_dr) begin
      r_tdo     <= w_dr_tdo;
      r_tdo_ena <= 1'b1;
    end else begin
      r_tdo     <= 1'b0;
      r_tdo_ena <= 1'b0;
    end
  end

  assign tdo              = r_tdo;
  assign tdo_ena          = r_tdo_ena;
  assign capture_dr       = w_capture_dr;
  assign shift_dr         = w_shift_dr;
  assign update_dr        = w_update_dr;
  assign test_logic_reset = w_tlr;
  assign gpio_data_ir     = w_sel_gdata;
  assign gpio_config_ir   = w_sel_gcfg;

endmodule

// File: tb/tb_jtag_tap.sv
// Scoreboard bench for jtag_tap: driver pushes expected outputs from a table-driven TAP model,
// a negedge monitor pops and compares; directed scenarios plus a random TMS/TDI walk.
module tb_jtag_tap;

  localparam logic [31:0] IDV = 32'h1000_0001;

  logic tck = 1'b0;
  logic reset = 1'b1;
  logic tms = 1'b1, tdi = 1'b0, gpios_tdo = 1'b0;
  logic tdo, tdo_ena, capture_dr, shift_dr, update_dr;
  logic gpio_data_ir, gpio_config_ir, test_logic_reset;

  jtag_tap dut (
    .tck(tck), .reset(reset), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_ena(tdo_ena),
    .gpios_tdo(gpios_tdo), .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .gpio_data_ir(gpio_data_ir), .gpio_config_ir(gpio_config_ir),
    .test_logic_reset(test_logic_reset)
  );

  always #5 tck = ~tck;

  int checks = 0;
  int failures = 0;

  // Model state numbering: 0 TLR, 1 RTI, 2-8 DR column (sel,cap,shift,ex1,pause,ex2,upd),
  // 9-15 IR column in the same order.
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  string paths[16] = '{"111", "", "1", "10", "100", "101", "1010", "10101", "1011",
                       "11", "110", "1100", "1101", "11010", "110101", "11011"};

  int         m_st;
  logic [3:0] m_ir, m_irsr;
  logic [31:0] m_id;
  logic       m_byp;

  logic [7:0] expq[$];
  logic       obs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: tdo settles on negedge; every queued expectation covers one negedge.
  initial begin
    logic [7:0] e, a;
    forever begin
      @(negedge tck);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = {tdo, tdo_ena, capture_dr, shift_dr, update_dr, test_logic_reset,
             gpio_data_ir, gpio_config_ir};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs t=%0t actual=%b required=%b (tdo,ena,cap,sh,upd,tlr,gd,gc)",
                   $time, a, e);
        end
        if (tdo_ena === 1'b1) obs.push_back(tdo);
      end
    end
  end

  function automatic void model_reset();
    m_st = 0; m_ir = 4'h1; m_irsr = 4'h0; m_id = 32'h0; m_byp = 1'b0;
  endfunction

  function automatic bit is_gpio_ir(input logic [3:0] ir);
    return (ir == 4'h2) || (ir == 4'h3);
  endfunction

  task automatic push_exp();
    logic t, en;
    t = 1'b0; en = 1'b0;
    if (m_st == 11) begin
      t = m_irsr[0]; en = 1'b1;
    end else if (m_st == 4) begin
      en = 1'b1;
      if (m_ir == 4'h1)         t = m_id[0];
      else if (is_gpio_ir(m_ir)) t = gpios_tdo;
      else                      t = m_byp;
    end
    expq.push_back({t, en, m_st == 3, m_st == 4, m_st == 8, m_st == 0,
                    m_ir == 4'h2, m_ir == 4'h3});
  endtask

  function automatic void model_advance(input logic t, input logic d);
    int nx;
    nx = t ? nxt1[m_st] : nxt0[m_st];
    if (m_st == 10)      m_irsr = 4'd1;
    else if (m_st == 11) m_irsr = (m_irsr >> 1) | (4'(d) << 3);
    else if (m_st == 15) m_ir = m_irsr;
    else if (m_st == 3) begin
      if (m_ir == 4'h1)               m_id = IDV;
      else if (!is_gpio_ir(m_ir))     m_byp = 1'b0;
    end else if (m_st == 4) begin
      if (m_ir == 4'h1)               m_id = (m_id >> 1) | (32'(d) << 31);
      else if (!is_gpio_ir(m_ir))     m_byp = d;
    end
    if (nx == 0) begin
      m_ir = 4'h1; m_irsr = 4'h0; m_id = 32'h0; m_byp = 1'b0;
    end
    m_st = nx;
  endfunction

  // Called at posedge+1: drive inputs, queue expectation for this cycle, advance on posedge.
  task automatic step(input logic t, input logic d);
    tms = t; tdi = d; gpios_tdo = 1'($urandom);
    push_exp();
    @(posedge tck);
    #1;
    model_advance(t, d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    push_exp();
    @(posedge tck);
    #1;
    reset = 1'b0;
  endtask

  task automatic shift_bits(input int n, input logic [31:0] din);
    for (int i = 0; i < n; i++) step(i == n - 1, din[i]);
  endtask

  task automatic goto_shift_dr();
    step(1, 1'($urandom)); step(0, 1'($urandom)); step(0, 1'($urandom));
  endtask

  task automatic goto_shift_ir();
    step(1, 1'($urandom)); step(1, 1'($urandom)); step(0, 1'($urandom)); step(0, 1'($urandom));
  endtask

  task automatic exit_to_idle();
    step(1, 1'($urandom)); step(0, 1'($urandom));
  endtask

  task automatic load_ir(input logic [3:0] v);
    goto_shift_ir(); shift_bits(4, 32'(v)); exit_to_idle();
  endtask

  function automatic logic [31:0] obs_val(input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n && i < obs.size(); i++) v[i] = obs[i];
    return v;
  endfunction

  task automatic dr_read(input int n, input logic [31:0] din, input string name,
                         input logic [31:0] req);
    goto_shift_dr();
    obs.delete();
    shift_bits(n, din);
    chk({name, "_len"}, obs.size(), n);
    chk(name, obs_val(n), req);
    exit_to_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] irv;
    model_reset();
    @(posedge tck); #1;
    chk("reset_tlr", test_logic_reset, 1);
    chk("reset_tdo", {tdo, tdo_ena, capture_dr, shift_dr, update_dr, gpio_data_ir, gpio_config_ir}, 0);
    do_reset();

    // Scenario 1: IDCODE after reset
    step(0, 1'($urandom));
    dr_read(32, $urandom, "idcode", IDV);

    // Scenario 3: BYPASS delays tdi by one bit
    load_ir(4'hF);
    dr_read(8, 32'hA5, "bypass_a5", 32'h4A);

    // Scenario 4: IR capture pattern and undefined opcode
    goto_shift_ir();
    obs.delete();
    shift_bits(4, 32'h7);
    chk("ir_capture", obs_val(4), 32'h1);
    exit_to_idle();
    chk("ir7_gpio_sel", {gpio_data_ir, gpio_config_ir}, 0);
    dr_read(8, 32'hA5, "ir7_bypass", 32'h4A);

    // Scenario 5: GPIO instructions
    load_ir(4'h3);
    chk("gpio_cfg_sel", {gpio_data_ir, gpio_config_ir}, 2'b01);
    load_ir(4'h2);
    chk("gpio_data_sel", {gpio_data_ir, gpio_config_ir}, 2'b10);
    goto_shift_dr(); shift_bits(12, $urandom); exit_to_idle();

    // Scenario 6: async reset during Shift-IR after two bits
    goto_shift_ir();
    step(0, 1'b1); step(0, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_rst_tlr", test_logic_reset, 1);
    chk("async_rst_out", {tdo, tdo_ena, shift_dr, gpio_data_ir, gpio_config_ir}, 0);
    model_reset();
    push_exp();
    @(posedge tck); #1;
    reset = 1'b0;
    step(0, 1'($urandom));
    dr_read(32, $urandom, "idcode_after_rst", IDV);

    // Scenario 2: five TMS=1 reach TLR from every state, IR back to IDCODE
    for (int s = 0; s < 16; s++) begin
      irv = (s % 2 == 0) ? 4'h2 : 4'h3;
      load_ir(irv);
      for (int i = 0; i < paths[s].len(); i++) step(paths[s][i] == "1", 1'($urandom));
      for (int i = 0; i < 5; i++) step(1, 1'($urandom));
      chk("tms5_tlr", {test_logic_reset, gpio_data_ir, gpio_config_ir}, 3'b100);
      step(0, 1'($urandom));
      dr_read(32, $urandom, "tms5_idcode", IDV);
    end

    // Random walk with occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) do_reset();
      else step(($urandom_range(9) < 3), 1'($urandom));
    end

    step(1, 1'b0);
    repeat (2) @(posedge tck);
    chk("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
